// File: rtl/eh2_ram_ctrl_pkg.sv
// Shared types and helpers for the RAM read-modify-write controller.
// Holds the controller state encoding and the byte-enable full-mask test.
package eh2_ram_ctrl_pkg;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    RMW  = 2'd2
  } state_e;

  localparam int MAX_BW = 64;

  // Callers zero-extend their enable vector; bits at or above bw are ignored.
  function automatic logic be_full(input logic [MAX_BW-1:0] be, input int bw);
    logic full;
    full = 1'b1;
    for (int i = 0; i < MAX_BW; i++) begin
      if ((i < bw) && !be[i]) full = 1'b0;
    end
    return full;
  endfunction

endpackage

// File: rtl/eh2_ram_be_merge.sv
// Combinational byte-lane merge: each output byte takes the new data when its
// enable is set, otherwise the old data. No state, zero latency.
module eh2_ram_be_merge #(
  parameter int WIDTH = 32,
  localparam int BW = WIDTH / 8
) (
  input  logic [WIDTH-1:0] i_old,
  input  logic [WIDTH-1:0] i_new,
  input  logic [BW-1:0]    i_be,
  output logic [WIDTH-1:0] o_merged
);

  for (genvar g = 0; g < BW; g++) begin : g_lane
    assign o_merged[8*g +: 8] = i_be[g] ? i_new[8*g +: 8] : i_old[8*g +: 8];
  end

endmodule

// File: rtl/eh2_ram_rmw_ctrl.sv
// Request controller for a non-byte-enabled single-port RAM: initialises the array
// after reset, passes reads/full writes through, and turns partial writes into RMW.
module eh2_ram_rmw_ctrl
  import eh2_ram_ctrl_pkg::*;
#(
  parameter int               DEPTH      = 4096,
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0,
  parameter int               AW         = $clog2(DEPTH),
  parameter int               BW         = WIDTH / 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [AW-1:0]    req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  input  logic [BW-1:0]    req_wbe,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             init_done,
  output logic             ram_me,
  output logic             ram_we,
  output logic [AW-1:0]    ram_adr,
  output logic [WIDTH-1:0] ram_d,
  input  logic [WIDTH-1:0] ram_q
);

  state_e           r_state;
  logic [AW-1:0]    r_init_cnt;
  logic [AW-1:0]    r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic [BW-1:0]    r_wbe;
  logic             r_rsp_valid;
  logic             r_init_done;

  logic             w_accept;
  logic             w_be_full;
  logic             w_be_none;
  logic             w_partial;
  logic [WIDTH-1:0] w_merged;

  assign w_accept  = req_valid && req_ready;
  assign w_be_full = be_full(MAX_BW'(req_wbe), BW);
  assign w_be_none = ~|req_wbe;
  assign w_partial = w_accept && req_write && !w_be_full && !w_be_none;

  // In RMW, ram_q carries the old word fetched by the read issued in IDLE.
  eh2_ram_be_merge #(.WIDTH(WIDTH)) u_merge (
    .i_old    (ram_q),
    .i_new    (r_wdata),
    .i_be     (r_wbe),
    .o_merged (w_merged)
  );

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_valid ? ram_q : '0;
  assign init_done = r_init_done;

  always_comb begin
    ram_me  = 1'b0;
    ram_we  = 1'b0;
    ram_adr = req_addr;
    ram_d   = req_wdata;
    unique case (r_state)
      INIT: begin
        ram_me  = 1'b1;
        ram_we  = 1'b1;
        ram_adr = r_init_cnt;
        ram_d   = INIT_VALUE;
      end
      IDLE: begin
        if (w_accept) begin
          if (!req_write) begin
            ram_me = 1'b1;
          end else if (w_be_full) begin
            ram_me = 1'b1;
            ram_we = 1'b1;
          end else if (!w_be_none) begin
            ram_me = 1'b1;
          end
        end
      end
      RMW: begin
        ram_me  = 1'b1;
        ram_we  = 1'b1;
        ram_adr = r_addr;
        ram_d   = w_merged;
      end
      default: ;
    endcase
    // Keep the macro quiet for the whole time reset is held, not just from the next edge.
    if (rst) begin
      ram_me = 1'b0;
      ram_we = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= INIT;
      r_init_cnt  <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wbe       <= '0;
      r_rsp_valid <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      unique case (r_state)
        INIT: begin
          // Compare against DEPTH-1 so non-power-of-two depths stop exactly on the last word.
          if (r_init_cnt == AW'(DEPTH - 1)) begin
            r_state     <= IDLE;
            r_init_done <= 1'b1;
            r_init_cnt  <= '0;
          end else begin
            r_init_cnt  <= r_init_cnt + 1'b1;
          end
        end
        IDLE: begin
          r_rsp_valid <= w_accept && !req_write;
          if (w_partial) begin
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_wbe   <= req_wbe;
            r_state <= RMW;
          end
        end
        RMW: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= INIT;
        end
      endcase
    end
  end

endmodule

// File: doc/eh2_ram_rmw_ctrl.md
Name: eh2_ram_rmw_ctrl

Overview:
- Request-side controller sitting directly upstream of a plain, non-byte-enabled single-port RAM macro (ME/WE/ADR/D/Q style, 1-cycle registered read).
- Presents a valid/ready request port with per-byte write enables to the requester.
- Turns partial-byte writes into an internal read-modify-write; full-word writes and reads pass through in a single cycle.
- After every reset it writes INIT_VALUE to the whole array before accepting traffic.

Parameters:
- DEPTH, 4096, number of RAM words.
- WIDTH, 32, data width in bits; must be a multiple of 8.
- INIT_VALUE, 0, word written to every address during the initialisation sweep.
- AW, $clog2(DEPTH), address width (derived; do not override).
- BW, WIDTH/8, byte-enable width (derived).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  controller accepts a request this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  AW  word address.
- req_wdata  in  WIDTH  write data.
- req_wbe  in  BW  byte enables; bit i covers bits [8i+7:8i].
- rsp_valid  out  1  read data valid; there is no backpressure.
- rsp_rdata  out  WIDTH  read data.
- init_done  out  1  initialisation sweep complete.
- ram_me  out  1  RAM enable.
- ram_we  out  1  RAM write enable.
- ram_adr  out  AW  RAM address.
- ram_d  out  WIDTH  RAM write data.
- ram_q  in  WIDTH  RAM read data; valid the cycle after ME=1, WE=0.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-high, and decided.
- Reset values:
  - state=INIT, init_cnt=0.
  - rsp_valid=0, init_done=0, req_ready=0.
  - ram_me=0, ram_we=0 while rst is asserted.
- States: INIT, IDLE, RMW.
- INIT:
  - Each cycle drives ram_me=1, ram_we=1, ram_adr=init_cnt, ram_d=INIT_VALUE, then increments init_cnt.
  - The cycle that writes DEPTH-1 transitions to IDLE.
  - init_done is registered and goes 1 in the first IDLE cycle; the sweep takes exactly DEPTH cycles.
  - req_ready=0 throughout.
- IDLE:
  - req_ready=1, driven combinationally from the state; a request is accepted when req_valid and req_ready.
  - Read: ram_me=1, ram_we=0, ram_adr=req_addr. rsp_valid=1 in the next cycle, with rsp_rdata=ram_q. Latency is 1; back-to-back reads give back-to-back responses.
  - Write with req_wbe all ones: ram_me=1, ram_we=1, ram_d=req_wdata. Single cycle, stays in IDLE, no response.
  - Write with req_wbe all zeros: accepted, no RAM access (ram_me=0), no response.
  - Partial write:
    - Issues a read of req_addr (ram_me=1, ram_we=0).
    - Latches addr, wdata and wbe, then goes to RMW.
    - Produces no rsp_valid.
  - No request: ram_me=0.
- RMW:
  - req_ready=0.
  - Drives ram_me=1, ram_we=1, ram_adr=latched addr.
  - ram_d per byte i = latched_wbe[i] ? latched_wdata byte i : ram_q byte i.
  - Returns to IDLE next cycle.
  - A partial write occupies 2 cycles; the earliest next acceptance is the cycle after RMW.
- Ordering: a read accepted right after RMW sees the merged data, because the RAM write completes in the RMW cycle.
- rsp_rdata is 0 whenever rsp_valid=0. It is gated, not a raw pass-through of ram_q.
- Reset mid-operation (INIT or RMW):
  - All state is discarded, the sweep restarts at address 0, and init_done drops immediately.
  - A pending RMW write is lost; this is by design.
- init_cnt wraps are impossible: the transition happens at DEPTH-1. DEPTH need not be a power of two, and the compare is against DEPTH-1, not the counter overflow.
- req_* inputs are ignored whenever req_ready=0, and the requester must hold them (valid/ready rule).

Decomposition:
- Package eh2_ram_ctrl_pkg holds:
  - the state enum {INIT, IDLE, RMW};
  - a function computing a full-mask check from a byte-enable vector.
- One sub-module, eh2_ram_be_merge, parameterised by WIDTH: purely combinational byte-lane merge (old, new, be) -> merged.
- Everything else stays in eh2_ram_rmw_ctrl.

Test Plan:
- Init sweep: DEPTH=16, INIT_VALUE=32'hDEADBEEF, release rst -> exactly 16 write cycles on addresses 0..15. init_done=1 in cycle 17, and a read of addr 9 returns 32'hDEADBEEF one cycle after acceptance.
- Full write then read: write addr 3 = 32'h12345678 with be=4'hF (1 cycle, ready stays 1), then read addr 3 -> rsp_valid next cycle with rsp_rdata=32'h12345678.
- Partial write via RMW:
  - Setup: addr 3 holds 32'h12345678; write be=4'b0101 with data 32'hAABBCCDD.
  - Required: req_ready=0 for one cycle, and the RAM sees a read then a write of 32'h12BB56DD.
  - A read in the following cycle returns 32'h12BB56DD.
- Zero-mask and back-to-back reads: a write with be=0 causes no RAM activity. Reads to addrs 1, 2, 3 on consecutive cycles -> three consecutive rsp_valid cycles with matching data.
- Reset mid-RMW: assert rst during the RMW cycle -> ram_me/ram_we drop asynchronously, init_done=0, and the sweep restarts at addr 0. Afterwards the target address reads INIT_VALUE.
